// File: rtl/mem_map_pkg.sv
// Address map, access-width encoding and STATUS layout shared by the data memory
// responder and its bench.
package mem_map_pkg;

   localparam int unsigned ADDR_W = 48;

   localparam logic [ADDR_W-1:0] ADDR_TXDATA = 48'h0000_0001_0000;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 48'h0000_0001_0004;
   localparam logic [ADDR_W-1:0] ADDR_CYCLES = 48'h0000_0001_0008;

   typedef enum logic [1:0] {
      W_WORD = 2'b00,
      W_BYTE = 2'b01,
      W_HALF = 2'b10
   } mem_width_t;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_OVF     = 2;
   localparam int unsigned STAT_UNM     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 5;

   // Word-granular address match; the two byte-offset bits never take part.
   function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] target);
      return addr[ADDR_W-1:2] == target[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with a registered head: a write becomes visible on the read side
// one cycle later. A push into a full FIFO is accepted only if a pop frees a slot.
module tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o,
   output logic [CntW-1:0]  count_o,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             pop_ok, push_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(DEPTH));
   assign count_o = count_q;
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign drop_o  = push_i & ~push_ok;
   // Head is forced to zero when nothing is queued so the stream idles clean.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data memory: word RAM plus TXDATA/STATUS/CYCLES registers, with a
// combinational load path that reflects the state before the current edge.
module data_mem_responder
   import mem_map_pkg::*;
#(
   parameter int unsigned DATA_W     = 48,
   parameter int unsigned RAM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MemWriteM,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [2:0]        MemoryControl,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              TxValid,
   output logic [7:0]        TxData,
   input  logic              TxReady
);

   localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

   logic              access, store, load;
   logic [13:0]       word_idx;
   logic [RamAw-1:0]  ram_idx;
   logic              sel_ram, sel_tx, sel_st, sel_cyc, unmapped;
   mem_width_t        width;
   logic              unused_addr;

   logic [DATA_W-1:0] ram_q [RAM_WORDS];
   logic [DATA_W-1:0] ram_rd, ram_load, ram_wdata;

   logic [47:0]       cycles_q, cycles_d;
   logic              ovf_q, ovf_d;
   logic              unm_q, unm_d;

   logic              fifo_full, fifo_empty, fifo_drop;
   logic [CntW-1:0]   fifo_count;
   logic [DATA_W-1:0] status;

   assign access = MemoryControl[2];
   assign store  = access & MemWriteM;
   assign load   = access & ~MemWriteM;
   assign width  = mem_width_t'(MemoryControl[1:0]);

   assign word_idx    = ALUOutM[15:2];
   assign ram_idx     = word_idx[RamAw-1:0];
   assign unused_addr = ^ALUOutM[1:0];

   assign sel_ram  = (ALUOutM[DATA_W-1:16] == '0) && ({1'b0, word_idx} < 15'(RAM_WORDS));
   assign sel_tx   = addr_hit(ADDR_W'(ALUOutM), ADDR_TXDATA);
   assign sel_st   = addr_hit(ADDR_W'(ALUOutM), ADDR_STATUS);
   assign sel_cyc  = addr_hit(ADDR_W'(ALUOutM), ADDR_CYCLES);
   assign unmapped = ~(sel_ram | sel_tx | sel_st | sel_cyc);

   assign ram_rd = ram_q[ram_idx];

   // Sub-word loads zero-extend; sub-word stores merge into the existing word.
   always_comb begin
      ram_load  = ram_rd;
      ram_wdata = WriteDataM;
      case (width)
         W_BYTE: begin
            ram_load  = {{(DATA_W-8){1'b0}}, ram_rd[7:0]};
            ram_wdata = {ram_rd[DATA_W-1:8], WriteDataM[7:0]};
         end
         W_HALF: begin
            ram_load  = {{(DATA_W-16){1'b0}}, ram_rd[15:0]};
            ram_wdata = {ram_rd[DATA_W-1:16], WriteDataM[15:0]};
         end
         default: begin
            ram_load  = ram_rd;
            ram_wdata = WriteDataM;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (store && sel_ram) ram_q[ram_idx] <= ram_wdata;
   end

   tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .CntW  (CntW)
   ) u_tx_fifo (
      .CLK     (CLK),
      .Reset   (Reset),
      .push_i  (store & sel_tx),
      .wdata_i (WriteDataM[7:0]),
      .pop_i   (TxReady),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop),
      .count_o (fifo_count),
      .rdata_o (TxData)
   );

   assign TxValid = ~fifo_empty;

   always_comb begin
      cycles_d = (store && sel_cyc) ? 48'd0 : cycles_q + 48'd1;
      ovf_d    = ovf_q;
      unm_d    = unm_q;
      if (store && sel_st) begin
         ovf_d = 1'b0;
         unm_d = 1'b0;
      end else begin
         if (fifo_drop)          ovf_d = 1'b1;
         if (access && unmapped) unm_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cycles_q <= '0;
         ovf_q    <= 1'b0;
         unm_q    <= 1'b0;
      end else begin
         cycles_q <= cycles_d;
         ovf_q    <= ovf_d;
         unm_q    <= unm_d;
      end
   end

   always_comb begin
      status                                = '0;
      status[STAT_FULL]                     = fifo_full;
      status[STAT_EMPTY]                    = fifo_empty;
      status[STAT_OVF]                      = ovf_q;
      status[STAT_UNM]                      = unm_q;
      status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
   end

   always_comb begin
      ReadDataM = '0;
      if (load) begin
         if (sel_ram)      ReadDataM = ram_load;
         else if (sel_st)  ReadDataM = status;
         else if (sel_cyc) ReadDataM = DATA_W'(cycles_q);
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM widths, TX stream, flags, counter, reset.
module tb_data_mem_responder;

   localparam logic [47:0] A_TX  = 48'h1_0000;
   localparam logic [47:0] A_ST  = 48'h1_0004;
   localparam logic [47:0] A_CYC = 48'h1_0008;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        MemWriteM;
   logic [47:0] ALUOutM;
   logic [47:0] WriteDataM;
   logic [2:0]  MemoryControl;
   logic [47:0] ReadDataM;
   logic        TxValid;
   logic [7:0]  TxData;
   logic        TxReady;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [47:0] tb_cyc;

   data_mem_responder #(
      .DATA_W     (48),
      .RAM_WORDS  (1024),
      .FIFO_DEPTH (8)
   ) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .MemWriteM     (MemWriteM),
      .ALUOutM       (ALUOutM),
      .WriteDataM    (WriteDataM),
      .MemoryControl (MemoryControl),
      .ReadDataM     (ReadDataM),
      .TxValid       (TxValid),
      .TxData        (TxData),
      .TxReady       (TxReady)
   );

   always #5 CLK = ~CLK;

   // Reference cycle count: zero in reset, +1 per edge afterwards.
   always @(posedge CLK or negedge Reset) begin
      if (!Reset) tb_cyc <= '0;
      else        tb_cyc <= tb_cyc + 48'd1;
   end

   task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic we, input logic [47:0] addr, input logic [47:0] wd,
                      input logic [2:0] ctl);
      MemWriteM     = we;
      ALUOutM       = addr;
      WriteDataM    = wd;
      MemoryControl = ctl;
      #1;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      Reset   = 1'b0;
      TxReady = 1'b0;
      put(1'b0, A_ST, 48'h0, 3'b100);
      #10;
      check_eq("rst_txvalid", {47'h0, TxValid}, 48'h0);
      check_eq("rst_txdata", {40'h0, TxData}, 48'h0);
      check_eq("rst_status", ReadDataM, 48'h002);
      step();
      Reset = 1'b1;

      // RAM word/byte/half access
      put(1'b1, 48'h40, 48'h1234_5678_9ABC, 3'b100);
      step();
      put(1'b0, 48'h40, 48'h0, 3'b100);
      check_eq("ld_word", ReadDataM, 48'h1234_5678_9ABC);
      put(1'b0, 48'h40, 48'h0, 3'b101);
      check_eq("ld_byte", ReadDataM, 48'hBC);
      put(1'b0, 48'h40, 48'h0, 3'b110);
      check_eq("ld_half", ReadDataM, 48'h9ABC);
      put(1'b0, 48'h42, 48'h0, 3'b111);
      check_eq("ld_w11_unalign", ReadDataM, 48'h1234_5678_9ABC);
      put(1'b0, 48'h40, 48'h0, 3'b000);
      check_eq("ld_noaccess", ReadDataM, 48'h0);
      put(1'b1, 48'h40, 48'hAAAA_AAAA_AAFF, 3'b101);
      step();
      put(1'b0, 48'h40, 48'h0, 3'b100);
      check_eq("st_byte", ReadDataM, 48'h1234_5678_9AFF);
      put(1'b1, 48'h40, 48'h5555_5555_1357, 3'b110);
      step();
      put(1'b0, 48'h40, 48'h0, 3'b100);
      check_eq("st_half", ReadDataM, 48'h1234_5678_1357);
      put(1'b1, 48'h40, 48'h0, 3'b000);
      step();
      put(1'b0, 48'h40, 48'h0, 3'b100);
      check_eq("st_noaccess", ReadDataM, 48'h1234_5678_1357);

      // TX stream: two pushes held, then drained
      put(1'b1, A_TX, 48'h41, 3'b100);
      check_eq("tx_nobypass", {47'h0, TxValid}, 48'h0);
      step();
      put(1'b1, A_TX, 48'h42, 3'b100);
      check_eq("tx_valid1", {47'h0, TxValid}, 48'h1);
      check_eq("tx_head41", {40'h0, TxData}, 48'h41);
      step();
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("tx_status2", ReadDataM, 48'h020);
      step();
      check_eq("tx_hold41", {40'h0, TxData}, 48'h41);
      put(1'b0, A_TX, 48'h0, 3'b100);
      check_eq("ld_txdata", ReadDataM, 48'h0);
      TxReady = 1'b1;
      step();
      check_eq("tx_head42", {40'h0, TxData}, 48'h42);
      step();
      check_eq("tx_drained", {47'h0, TxValid}, 48'h0);
      step();
      check_eq("tx_empty_ready", {47'h0, TxValid}, 48'h0);
      TxReady = 1'b0;

      // Overflow handling
      for (int i = 0; i < 8; i++) begin
         put(1'b1, A_TX, 48'h10 + 48'(i), 3'b100);
         step();
      end
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("fifo_full", ReadDataM, 48'h081);
      put(1'b1, A_TX, 48'h5A, 3'b100);
      step();
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("fifo_ovf", ReadDataM, 48'h085);
      check_eq("ovf_head", {40'h0, TxData}, 48'h10);
      TxReady = 1'b1;
      put(1'b1, A_TX, 48'h5B, 3'b100);
      step();
      TxReady = 1'b0;
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("push_pop_full", ReadDataM, 48'h085);
      check_eq("pp_head", {40'h0, TxData}, 48'h11);
      put(1'b1, A_ST, 48'h0, 3'b100);
      step();
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("ovf_clear", ReadDataM, 48'h081);
      put(1'b0, 48'h0, 48'h0, 3'b000);
      TxReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("drain%0d", i), {40'h0, TxData},
                  (i == 7) ? 48'h5B : 48'h11 + 48'(i));
         step();
      end
      check_eq("drain_done", {47'h0, TxValid}, 48'h0);
      TxReady = 1'b0;

      // Cycle counter
      put(1'b0, A_CYC, 48'h0, 3'b100);
      check_eq("cyc_a", ReadDataM, tb_cyc);
      step();
      check_eq("cyc_b", ReadDataM, tb_cyc);
      put(1'b1, A_CYC, 48'hFFFF, 3'b100);
      step();
      put(1'b0, A_CYC, 48'h0, 3'b100);
      check_eq("cyc_cleared", ReadDataM, 48'h0);
      step();
      check_eq("cyc_after", ReadDataM, 48'h1);

      // Unmapped accesses
      put(1'b0, 48'h2_0000, 48'h0, 3'b100);
      check_eq("unm_load", ReadDataM, 48'h0);
      step();
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("unm_set", ReadDataM, 48'h00A);
      put(1'b1, A_ST, 48'h0, 3'b100);
      step();
      put(1'b1, 48'h1000, 48'hDEAD, 3'b100);
      step();
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("unm_store_ram_oob", ReadDataM, 48'h00A);

      // Reset in the middle of a queued stream
      for (int i = 0; i < 3; i++) begin
         put(1'b1, A_TX, 48'h70 + 48'(i), 3'b100);
         step();
      end
      put(1'b0, A_ST, 48'h0, 3'b100);
      check_eq("pre_rst_status", ReadDataM, 48'h038);
      #1;
      Reset = 1'b0;
      #1;
      check_eq("mid_rst_valid", {47'h0, TxValid}, 48'h0);
      check_eq("mid_rst_data", {40'h0, TxData}, 48'h0);
      check_eq("mid_rst_status", ReadDataM, 48'h002);
      put(1'b0, A_CYC, 48'h0, 3'b100);
      check_eq("mid_rst_cyc", ReadDataM, 48'h0);
      put(1'b0, 48'h40, 48'h0, 3'b100);
      check_eq("ram_retained", ReadDataM, 48'h1234_5678_1357);
      step();
      Reset = 1'b1;
      put(1'b0, 48'h0, 48'h0, 3'b000);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
